// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with sequential/branch/jump/register/return-stack next-PC selection.
// The return-address stack and its overflow/underflow flags are built only when PC_RAS_EN is defined.
module pc_sequencer #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       pc_sel,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misaligned,
    output logic             ras_overflow,
    output logic             ras_underflow
);
    logic [WIDTH-1:0] branch_disp, sel_target, target;
    assign pc_plus4 = pc_out + WIDTH'(4);
    assign branch_disp = WIDTH'($signed(branch_offset)) << 2;
    assign sel_target = pc_sel == 2'b00 ? pc_plus4 :
                        pc_sel == 2'b01 ? (branch_taken ? pc_plus4 + branch_disp : pc_plus4) :
                        pc_sel == 2'b10 ? jump_target : reg_target;
`ifdef PC_RAS_EN
    localparam int AW = $clog2(RAS_DEPTH);
    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [AW-1:0] top, wr_ptr;
    logic [AW:0] count;
    logic empty, full, pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(RAS_DEPTH);
    assign pop = ret && !empty;
    // a push that accompanies a pop lands in the slot just vacated, so top stays put
    assign wr_ptr = pop ? top : top + AW'(1);
    assign target = ret ? (pop ? stack[top] : reg_target) : sel_target;
    always_ff @(posedge clock)
        if (!stall && call) stack[wr_ptr] <= pc_plus4;
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            top <= '0;
            count <= '0;
            ras_overflow <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (stall) begin
            ras_overflow <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (call) top <= wr_ptr;
            else if (pop) top <= top - AW'(1);
            if (call && !pop && !full) count <= count + (AW+1)'(1);
            else if (pop && !call) count <= count - (AW+1)'(1);
            ras_overflow <= call && full && !pop;
            ras_underflow <= ret && empty;
        end
`else
    localparam int unused_depth = RAS_DEPTH;
    logic unused_call;
    assign unused_call = call;
    assign target = ret ? reg_target : sel_target;
    assign ras_overflow = 1'b0;
    assign ras_underflow = 1'b0;
`endif
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            pc_out <= RESET_VECTOR;
            misaligned <= 1'b0;
        end else if (stall) begin
            misaligned <= 1'b0;
        end else begin
            pc_out <= {target[WIDTH-1:2], 2'b00};
            misaligned <= |target[1:0];
        end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with an in-bench list-based reference model checked every cycle.
// Return-stack scenarios run only when PC_RAS_EN is defined.
module tb_pc_sequencer;
    logic        clock = 1'b0;
    logic        reset, stall, branch_taken, call, ret;
    logic [1:0]  pc_sel;
    logic [15:0] branch_offset;
    logic [31:0] jump_target, reg_target, pc_out, pc_plus4;
    logic        misaligned, ras_overflow, ras_underflow;
    int n_checks = 0;
    int n_fail = 0;
    logic run = 1'b0;

    pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h400), .RAS_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .stall(stall), .pc_sel(pc_sel),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump_target(jump_target), .reg_target(reg_target), .call(call), .ret(ret),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .misaligned(misaligned),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clock = ~clock;

    // reference model: stack kept as a list, index 0 = oldest entry
    logic [31:0] m_pc;
    logic [3:0][31:0] m_stk;
    int m_n;
    logic m_mis, m_ovf, m_unf;

    always @(posedge clock or posedge reset) begin : model
        logic [31:0] p4, tgt;
        logic [3:0][31:0] s;
        int n;
        logic ovf, unf;
        if (reset) begin
            m_pc <= 32'h400; m_n <= 0; m_mis <= 1'b0; m_ovf <= 1'b0; m_unf <= 1'b0;
        end else if (stall) begin
            m_mis <= 1'b0; m_ovf <= 1'b0; m_unf <= 1'b0;
        end else begin
            p4 = m_pc + 32'd4;
            s = m_stk; n = m_n; ovf = 1'b0; unf = 1'b0;
            case (pc_sel)
                2'd0: tgt = p4;
                2'd1: tgt = branch_taken ? p4 + 32'($signed(branch_offset)) * 4 : p4;
                2'd2: tgt = jump_target;
                default: tgt = reg_target;
            endcase
`ifdef PC_RAS_EN
            if (ret) begin
                if (n > 0) begin tgt = s[n-1]; n--; end
                else begin tgt = reg_target; unf = 1'b1; end
            end
            if (call) begin
                if (n == 4) begin
                    ovf = 1'b1;
                    for (int i = 0; i < 3; i++) s[i] = s[i+1];
                    s[3] = p4;
                end else begin
                    s[n] = p4; n++;
                end
            end
`else
            if (ret) tgt = reg_target;
`endif
            m_pc <= {tgt[31:2], 2'b00}; m_mis <= |tgt[1:0];
            m_stk <= s; m_n <= n; m_ovf <= ovf; m_unf <= unf;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock)
        if (run && !reset) begin
            chk("model_pc", pc_out, m_pc);
            chk("model_pc4", pc_plus4, m_pc + 32'd4);
            chk("model_mis", misaligned, m_mis);
            chk("model_ovf", ras_overflow, m_ovf);
            chk("model_unf", ras_underflow, m_unf);
        end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic jump(input logic [31:0] a);
        pc_sel = 2'b10; jump_target = a; step(); pc_sel = 2'b00;
    endtask

    task automatic call_jump(input logic [31:0] a);
        call = 1'b1; jump(a); call = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pc_sel = 2'b00; branch_taken = 1'b0; branch_offset = '0;
        jump_target = '0; reg_target = '0; call = 1'b0; ret = 1'b0;
        repeat (2) @(posedge clock); #1;
        chk("reset_pc", pc_out, 32'h400);
        chk("reset_mis", misaligned, 1'b0);
        chk("reset_ovf", ras_overflow, 1'b0);
        chk("reset_unf", ras_underflow, 1'b0);
        #2 reset = 1'b0; run = 1'b1;
        step(); chk("seq_1", pc_out, 32'h404);
        step(); chk("seq_2", pc_out, 32'h408);
        step(); chk("seq_3", pc_out, 32'h40C);
        jump(32'h100); chk("jump", pc_out, 32'h100);
        pc_sel = 2'b01; branch_offset = 16'hFFFE; branch_taken = 1'b1; step();
        chk("branch_taken", pc_out, 32'h0FC);
        jump(32'h100);
        pc_sel = 2'b01; branch_taken = 1'b0; step();
        chk("branch_not_taken", pc_out, 32'h104);
        pc_sel = 2'b00;
        jump(32'h20);
        stall = 1'b1; reg_target = 32'h1003; pc_sel = 2'b11;
        step(); chk("stall_1", pc_out, 32'h20);
        step(); chk("stall_2", pc_out, 32'h20);
        chk("stall_mis", misaligned, 1'b0);
        #2 reset = 1'b1;
        #1 chk("async_reset", pc_out, 32'h400);
        #2 reset = 1'b0; stall = 1'b0; pc_sel = 2'b00;
        step(); chk("after_reset", pc_out, 32'h404);
        pc_sel = 2'b11; reg_target = 32'h1002; step();
        chk("mis_pc", pc_out, 32'h1000);
        chk("mis_pulse", misaligned, 1'b1);
        pc_sel = 2'b00; step();
        chk("mis_clear_pc", pc_out, 32'h1004);
        chk("mis_clear", misaligned, 1'b0);
        jump(32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        step(); chk("wrap_pc", pc_out, 32'h0);
`ifdef PC_RAS_EN
        jump(32'h10);
        for (int i = 1; i <= 5; i++) begin
            call_jump(32'((i + 1) * 16));
            chk("ras_ovf", ras_overflow, 32'(i == 5));
        end
        stall = 1'b1; ret = 1'b1; step();
        chk("stall_ret_pc", pc_out, 32'h60);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); chk("ret_pc", pc_out, 32'h54 - 32'(i * 16));
            chk("ret_unf", ras_underflow, 1'b0);
        end
        reg_target = 32'h80; step();
        chk("underflow_pc", pc_out, 32'h80);
        chk("underflow", ras_underflow, 1'b1);
        ret = 1'b0; step();
        chk("underflow_clear", ras_underflow, 1'b0);
        jump(32'h1FC);
        call_jump(32'h300);
        chk("pre_callret", pc_out, 32'h300);
        call = 1'b1; ret = 1'b1; step();
        chk("callret_pc", pc_out, 32'h200);
        call = 1'b0; step();
        chk("callret_top", pc_out, 32'h304);
        chk("callret_unf", ras_underflow, 1'b0);
        step();
        chk("callret_empty", pc_out, 32'h80);
        chk("callret_empty_unf", ras_underflow, 1'b1);
        ret = 1'b0;
`else
        ret = 1'b1; call = 1'b1; reg_target = 32'h500; step();
        chk("ret_reg", pc_out, 32'h500);
        chk("no_ovf", ras_overflow, 1'b0);
        chk("no_unf", ras_underflow, 1'b0);
        ret = 1'b0; call = 1'b0;
`endif
        step();
        @(negedge clock); #1;
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
